multi_store_unit: RTL and testbench

//  Store-side counterpart of the load-path sign/zero extension in the multi-cycle MIPS datapath.

---
 rtl/multi_store_unit.sv | 128 ++++++++++++
 tb/tb_multi_store_unit.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_store_unit.sv
`default_nettype none
// ==== multi_store_unit : SW/SH/SB store narrowing onto a word-only memory (read-modify-write) ====
// ==== rev 1.0                                                                                   ====
module multi_store_unit #(
  parameter int MEM_RD_LAT = 1,
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        misalign,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  input  logic [31:0] mem_rdata,
  output logic        mem_wr,
  output logic [31:0] mem_wdata
);

  localparam logic [1:0] OP_SW    = 2'b00;
  localparam logic [1:0] OP_SH    = 2'b01;
  localparam logic [2:0] LAT_INIT = 3'(MEM_RD_LAT);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WAIT = 3'd2,
    S_WR   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t      state, next_state;
  logic [1:0]  lat_op;
  logic [1:0]  lat_lo;
  logic [15:0] lat_data;
  logic [2:0]  wait_cnt;
  logic        fault_flag;
  logic        start_fault;
  logic        half_lane;
  logic [1:0]  byte_lane;
  logic [31:0] merged;

  assign start_fault = (op == 2'b11)
                     | ((op == OP_SW) & (addr[1:0] != 2'b00))
                     | ((op == OP_SH) & addr[0]);

  // Big-endian lanes are the little-endian lane index mirrored within the word.
  assign half_lane = lat_lo[1] ^ BIG_ENDIAN;
  assign byte_lane = lat_lo ^ {2{BIG_ENDIAN}};

  always_comb begin
    merged = mem_rdata;
    if (lat_op == OP_SH) merged[{half_lane, 4'b0000} +: 16] = lat_data;
    else                 merged[{byte_lane, 3'b000} +: 8]   = lat_data[7:0];
  end

  always_comb begin
    next_state = state;
    busy       = 1'b1;
    done       = 1'b0;
    misalign   = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          if (start_fault)      next_state = S_DONE;
          else if (op == OP_SW) next_state = S_WR;
          else                  next_state = S_RD;
        end
      end
      S_RD: begin
        mem_rd     = 1'b1;
        next_state = S_WAIT;
      end
      S_WAIT: if (wait_cnt <= 3'd1) next_state = S_WR;
      S_WR: begin
        mem_wr     = 1'b1;
        next_state = S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        misalign   = fault_flag;
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      lat_op     <= 2'b00;
      lat_lo     <= 2'b00;
      lat_data   <= 16'h0000;
      wait_cnt   <= 3'd0;
      fault_flag <= 1'b0;
      mem_addr   <= 32'h0;
      mem_wdata  <= 32'h0;
    end else begin
      state <= next_state;
      case (state)
        S_IDLE: if (start) begin
          lat_op     <= op;
          lat_lo     <= addr[1:0];
          lat_data   <= wdata[15:0];
          fault_flag <= start_fault;
          mem_addr   <= {addr[31:2], 2'b00};
          if (op == OP_SW) mem_wdata <= wdata;
        end
        S_RD: wait_cnt <= LAT_INIT;
        S_WAIT: begin
          wait_cnt <= wait_cnt - 3'd1;
          // The read word is valid in the last WAIT cycle; merge it in as it is captured.
          if (wait_cnt <= 3'd1) mem_wdata <= merged;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multi_store_unit.sv
`default_nettype none
`timescale 1ns/1ps
// Bench for multi_store_unit: instance 0 (LAT=1, little-endian), instance 1 (LAT=3, big-endian).
module tb_multi_store_unit;

  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst       [2];
  logic        start     [2];
  logic [1:0]  op        [2];
  logic [31:0] addr      [2];
  logic [31:0] wdata     [2];
  logic        busy      [2];
  logic        done      [2];
  logic        misalign  [2];
  logic [31:0] mem_addr  [2];
  logic        mem_rd    [2];
  logic [31:0] mem_rdata [2];
  logic        mem_wr    [2];
  logic [31:0] mem_wdata [2];

  logic [31:0] mem       [2][256];
  logic [31:0] model_mem [2][256];

  int n_chk  = 0;
  int n_pass = 0;

  multi_store_unit #(.MEM_RD_LAT(LAT0), .BIG_ENDIAN(1'b0)) u0 (
    .clk(clk), .rst(rst[0]), .start(start[0]), .op(op[0]), .addr(addr[0]), .wdata(wdata[0]),
    .busy(busy[0]), .done(done[0]), .misalign(misalign[0]), .mem_addr(mem_addr[0]),
    .mem_rd(mem_rd[0]), .mem_rdata(mem_rdata[0]), .mem_wr(mem_wr[0]), .mem_wdata(mem_wdata[0])
  );

  multi_store_unit #(.MEM_RD_LAT(LAT1), .BIG_ENDIAN(1'b1)) u1 (
    .clk(clk), .rst(rst[1]), .start(start[1]), .op(op[1]), .addr(addr[1]), .wdata(wdata[1]),
    .busy(busy[1]), .done(done[1]), .misalign(misalign[1]), .mem_addr(mem_addr[1]),
    .mem_rd(mem_rd[1]), .mem_rdata(mem_rdata[1]), .mem_wr(mem_wr[1]), .mem_wdata(mem_wdata[1])
  );

  function automatic int lat_of(input int i);
    return (i == 0) ? LAT0 : LAT1;
  endfunction

  function automatic bit be_of(input int i);
    return i != 0;
  endfunction

  function automatic bit is_fault(input logic [1:0] o, input logic [31:0] a);
    return (o == 2'b11) || (o == 2'b00 && a[1:0] != 2'b00) || (o == 2'b01 && a[0]);
  endfunction

  // Store result computed from lane arithmetic on the old memory word.
  function automatic logic [31:0] ref_merge(input bit be, input logic [1:0] o,
                                            input logic [31:0] a, input logic [31:0] wd,
                                            input logic [31:0] old);
    int lane;
    logic [31:0] mask;
    if (o == 2'b00) return wd;
    if (o == 2'b01) begin
      lane = be ? 1 - int'(a[1]) : int'(a[1]);
      mask = 32'hFFFF << (16 * lane);
      return (old & ~mask) | ((wd & 32'hFFFF) << (16 * lane));
    end
    lane = be ? 3 - int'(a[1:0]) : int'(a[1:0]);
    mask = 32'hFF << (8 * lane);
    return (old & ~mask) | ((wd & 32'hFF) << (8 * lane));
  endfunction

  // Memory with MEM_RD_LAT read latency; drives an inverted word whenever data is not due.
  int         due  [2];
  bit         pend [2];
  logic [7:0] rd_idx [2];
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst[i]) pend[i] = 1'b0;
      else begin
        if (mem_wr[i]) mem[i][mem_addr[i][9:2]] = mem_wdata[i];
        if (mem_rd[i]) begin
          pend[i] = 1'b1; due[i] = lat_of(i); rd_idx[i] = mem_addr[i][9:2];
        end else if (pend[i] && due[i] > 0) due[i]--;
      end
      mem_rdata[i] = (pend[i] && due[i] == 0) ? mem[i][rd_idx[i]] : ~mem[i][rd_idx[i]];
      if (pend[i] && due[i] == 0) pend[i] = 1'b0;
    end
  end

  // Issues one request on instance i and records what the memory port did, relative to the start cycle.
  task automatic run_req(input int i, input logic [1:0] o, input logic [31:0] a, input logic [31:0] wd,
                         output int rd_n, output int rd_c, output int wr_n, output int wr_c,
                         output int done_c, output logic [31:0] wr_d, output logic [31:0] wr_a,
                         output logic [31:0] rd_a, output logic mis, output bit clash);
    rd_n = 0; wr_n = 0; rd_c = -1; wr_c = -1; done_c = -1;
    wr_d = 32'h0; wr_a = 32'h0; rd_a = 32'h0; mis = 1'b0; clash = 1'b0;
    @(negedge clk);
    start[i] = 1'b1; op[i] = o; addr[i] = a; wdata[i] = wd;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      start[i] = 1'b0; op[i] = 2'($urandom); addr[i] = $urandom; wdata[i] = $urandom;
      if (mem_rd[i]) begin rd_n++; rd_c = k; rd_a = mem_addr[i]; end
      if (mem_wr[i]) begin wr_n++; wr_c = k; wr_d = mem_wdata[i]; wr_a = mem_addr[i]; end
      if (mem_rd[i] && mem_wr[i]) clash = 1'b1;
      if (done[i]) begin done_c = k; mis = misalign[i]; break; end
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      n_chk++;
      if ({busy[i], done[i], misalign[i], mem_rd[i], mem_wr[i], mem_addr[i], mem_wdata[i]} !== '0)
        $display("FAIL reset_state inst%0d: busy=%b done=%b mis=%b rd=%b wr=%b addr=%h wdata=%h, want all 0",
                 i, busy[i], done[i], misalign[i], mem_rd[i], mem_wr[i], mem_addr[i], mem_wdata[i]);
      else n_pass++;
    end
    @(negedge clk);
    rst[0] = 1'b0; rst[1] = 1'b0;
  endtask

  task automatic test_sw();
    int rn, rc, wn, wc, dc; logic [31:0] wd_o, wa, ra; logic mis; bit cl;
    run_req(0, 2'b00, 32'h100, 32'hDEADBEEF, rn, rc, wn, wc, dc, wd_o, wa, ra, mis, cl);
    n_chk++;
    if (wc !== 1 || wn !== 1 || dc !== 2 || rn !== 0 || mis !== 1'b0)
      $display("FAIL sw_timing: wr_cyc=%0d wr_n=%0d done_cyc=%0d rd_n=%0d mis=%b, want 1 1 2 0 0", wc, wn, dc, rn, mis);
    else n_pass++;
    n_chk++;
    if (wd_o !== 32'hDEADBEEF || wa !== 32'h100)
      $display("FAIL sw_data: wdata=%h addr=%h, want deadbeef 00000100", wd_o, wa);
    else n_pass++;
    model_mem[0][8'h40] = 32'hDEADBEEF;
  endtask

  task automatic test_sub_word();
    int rn, rc, wn, wc, dc; logic [31:0] wd_o, wa, ra; logic mis; bit cl;
    mem[0][8'h80] = 32'h11223344; model_mem[0][8'h80] = 32'h11223344;
    run_req(0, 2'b10, 32'h203, 32'h000000AB, rn, rc, wn, wc, dc, wd_o, wa, ra, mis, cl);
    n_chk++;
    if (rc !== 1 || wc !== 3 || dc !== 4 || wd_o !== 32'hAB223344 || wa !== 32'h200 || ra !== 32'h200)
      $display("FAIL sb_le: rd_cyc=%0d wr_cyc=%0d done_cyc=%0d wdata=%h addr=%h, want 1 3 4 ab223344 00000200",
               rc, wc, dc, wd_o, wa);
    else n_pass++;
    model_mem[0][8'h80] = 32'hAB223344;

    for (int i = 0; i < 2; i++) begin
      mem[i][8'h10] = 32'h11223344; model_mem[i][8'h10] = 32'h11223344;
      run_req(i, 2'b01, 32'h042, 32'hFFFF5566, rn, rc, wn, wc, dc, wd_o, wa, ra, mis, cl);
      n_chk++;
      if (wd_o !== ((i == 0) ? 32'h55663344 : 32'h11225566) || wc !== 2 + lat_of(i) || dc !== 3 + lat_of(i) || cl)
        $display("FAIL sh_inst%0d: wdata=%h wr_cyc=%0d done_cyc=%0d clash=%b, want %h %0d %0d 0", i, wd_o, wc, dc, cl,
                 (i == 0) ? 32'h55663344 : 32'h11225566, 2 + lat_of(i), 3 + lat_of(i));
      else n_pass++;
      model_mem[i][8'h10] = (i == 0) ? 32'h55663344 : 32'h11225566;
    end
  endtask

  task automatic test_faults();
    int rn, rc, wn, wc, dc; logic [31:0] wd_o, wa, ra; logic mis; bit cl;
    logic [1:0]  f_op   [3] = '{2'b00, 2'b01, 2'b11};
    logic [31:0] f_addr [3] = '{32'h101, 32'h003, 32'h100};
    for (int t = 0; t < 3; t++) begin
      run_req(0, f_op[t], f_addr[t], $urandom, rn, rc, wn, wc, dc, wd_o, wa, ra, mis, cl);
      n_chk++;
      if (dc !== 1 || mis !== 1'b1 || rn !== 0 || wn !== 0)
        $display("FAIL fault_op%0d: done_cyc=%0d mis=%b rd_n=%0d wr_n=%0d, want 1 1 0 0", f_op[t], dc, mis, rn, wn);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    int rn, rc, wn, wc, dc; logic [31:0] wd_o, wa, ra; logic mis; bit cl;
    int late;
    @(negedge clk);
    start[1] = 1'b1; op[1] = 2'b10; addr[1] = 32'h203; wdata[1] = 32'h5A;
    @(negedge clk);
    start[1] = 1'b0;
    @(negedge clk);
    n_chk++;
    if (busy[1] !== 1'b1 || mem_rd[1] !== 1'b0 || mem_wr[1] !== 1'b0)
      $display("FAIL rstmid_wait: busy=%b rd=%b wr=%b, want 1 0 0", busy[1], mem_rd[1], mem_wr[1]);
    else n_pass++;
    rst[1] = 1'b1;
    #1;
    n_chk++;
    if ({busy[1], done[1], misalign[1], mem_rd[1], mem_wr[1], mem_addr[1], mem_wdata[1]} !== '0)
      $display("FAIL rstmid_async: busy=%b done=%b rd=%b wr=%b addr=%h wdata=%h, want all 0",
               busy[1], done[1], mem_rd[1], mem_wr[1], mem_addr[1], mem_wdata[1]);
    else n_pass++;
    @(negedge clk);
    rst[1] = 1'b0;
    late = 0;
    repeat (10) begin
      @(negedge clk);
      if (mem_wr[1] || done[1]) late++;
    end
    n_chk++;
    if (late !== 0) $display("FAIL rstmid_lost: %0d wr/done cycles after reset, want 0", late);
    else n_pass++;
    run_req(1, 2'b00, 32'h0, 32'hCAFEF00D, rn, rc, wn, wc, dc, wd_o, wa, ra, mis, cl);
    n_chk++;
    if (wc !== 1 || dc !== 2 || wd_o !== 32'hCAFEF00D || wa !== 32'h0 || mis !== 1'b0)
      $display("FAIL rstmid_sw0: wr_cyc=%0d done_cyc=%0d wdata=%h addr=%h mis=%b, want 1 2 cafef00d 0 0",
               wc, dc, wd_o, wa, mis);
    else n_pass++;
    model_mem[1][0] = 32'hCAFEF00D;
    run_req(1, 2'b00, 32'h1, 32'h12345678, rn, rc, wn, wc, dc, wd_o, wa, ra, mis, cl);
    n_chk++;
    if (dc !== 1 || mis !== 1'b1 || wn !== 0)
      $display("FAIL rstmid_sw1: done_cyc=%0d mis=%b wr_n=%0d, want 1 1 0", dc, mis, wn);
    else n_pass++;
  endtask

  task automatic test_random();
    int rn, rc, wn, wc, dc; logic [31:0] wd_o, wa, ra; logic mis; bit cl;
    int i, e_rn, e_rc, e_wn, e_wc, e_dc;
    logic [1:0] o; logic [31:0] a, wd, e_d;
    bit f;
    for (int n = 0; n < 40; n++) begin
      i = int'($urandom_range(1, 0)); o = 2'($urandom); a = $urandom; wd = $urandom;
      f = is_fault(o, a);
      e_d = ref_merge(be_of(i), o, a, wd, model_mem[i][a[9:2]]);
      if (f)                begin e_rn = 0; e_rc = -1; e_wn = 0; e_wc = -1;            e_dc = 1; end
      else if (o == 2'b00)  begin e_rn = 0; e_rc = -1; e_wn = 1; e_wc = 1;             e_dc = 2; end
      else                  begin e_rn = 1; e_rc = 1;  e_wn = 1; e_wc = 2 + lat_of(i); e_dc = 3 + lat_of(i); end
      run_req(i, o, a, wd, rn, rc, wn, wc, dc, wd_o, wa, ra, mis, cl);
      n_chk++;
      if (rn !== e_rn || rc !== e_rc || wn !== e_wn || wc !== e_wc || dc !== e_dc || mis !== f || cl)
        $display("FAIL rand_timing inst%0d op%0d addr=%h: rd=%0d@%0d wr=%0d@%0d done@%0d mis=%b clash=%b, want rd=%0d@%0d wr=%0d@%0d done@%0d mis=%b",
                 i, o, a, rn, rc, wn, wc, dc, mis, cl, e_rn, e_rc, e_wn, e_wc, e_dc, f);
      else n_pass++;
      if (!f) begin
        n_chk++;
        if (wd_o !== e_d || wa !== {a[31:2], 2'b00} || (o != 2'b00 && ra !== wa))
          $display("FAIL rand_data inst%0d op%0d addr=%h: wdata=%h wr_addr=%h rd_addr=%h, want %h %h",
                   i, o, a, wd_o, wa, ra, e_d, {a[31:2], 2'b00});
        else n_pass++;
        model_mem[i][a[9:2]] = e_d;
      end
    end
  endtask

  // start held high on the LAT=3 instance: a new request is taken only on each return to IDLE.
  task automatic test_back_to_back();
    int next_acc, e_wr_c, e_done_c, n_acc, n_wr_exp, n_wr, n_done, bad;
    logic [31:0] e_d; logic e_mis; logic [1:0] o; logic [31:0] a;
    next_acc = 0; e_wr_c = -1; e_done_c = -1; n_acc = 0; n_wr_exp = 0; n_wr = 0; n_done = 0; bad = 0;
    e_d = 32'h0; e_mis = 1'b0;
    for (int c = 0; c < 160; c++) begin
      @(negedge clk);
      if (mem_rd[1] && mem_wr[1]) bad++;
      if (mem_wr[1]) begin
        n_wr++;
        n_chk++;
        if (c !== e_wr_c || mem_wdata[1] !== e_d)
          $display("FAIL b2b_wr cycle %0d: wdata=%h, want cycle %0d wdata %h", c, mem_wdata[1], e_wr_c, e_d);
        else n_pass++;
      end
      if (done[1]) begin
        n_done++;
        n_chk++;
        if (c !== e_done_c || misalign[1] !== e_mis)
          $display("FAIL b2b_done cycle %0d: mis=%b, want cycle %0d mis %b", c, misalign[1], e_done_c, e_mis);
        else n_pass++;
      end
      o = 2'($urandom); a = $urandom;
      start[1] = (c < 140); op[1] = o; addr[1] = a; wdata[1] = $urandom;
      if (c < 140 && c == next_acc) begin
        n_acc++;
        e_mis = is_fault(o, a);
        if (e_mis) begin
          e_done_c = c + 1; next_acc = c + 2;
        end else begin
          e_d = ref_merge(1'b1, o, a, wdata[1], model_mem[1][a[9:2]]);
          model_mem[1][a[9:2]] = e_d;
          n_wr_exp++;
          e_wr_c   = (o == 2'b00) ? c + 1 : c + 2 + LAT1;
          e_done_c = e_wr_c + 1;
          next_acc = e_done_c + 1;
        end
      end
    end
    n_chk++;
    if (n_wr !== n_wr_exp || n_done !== n_acc || bad !== 0)
      $display("FAIL b2b_counts: writes=%0d dones=%0d clash=%0d, want writes=%0d dones=%0d clash=0",
               n_wr, n_done, bad, n_wr_exp, n_acc);
    else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; start[i] = 1'b0; op[i] = 2'b00; addr[i] = 32'h0; wdata[i] = 32'h0;
      for (int w = 0; w < 256; w++) begin
        mem[i][w] = $urandom;
        model_mem[i][w] = mem[i][w];
      end
    end
    repeat (2) @(negedge clk);
    test_reset();
    test_sw();
    test_sub_word();
    test_faults();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
